corefifo_ptr_sync_mc: RTL and testbench
=======================================

# corefifo_ptr_sync_mc

Multi-channel, parametrised successor to the COREFIFO N-stage pointer synchronizer. It sits in the destination clock domain of an asynchronous FIFO. It resynchronises NUM_CH Gray-coded pointers through NUM_STAGES flops and provides each pointer in both Gray and binary form. Per channel it also flags updates and detects illegal multi-bit Gray transitions, which indicate CDC violations or a corrupted source. A start-up qualifier masks the flush period after reset.

## Interface
Parameters:
- NUM_STAGES, 2: synchronizer depth. Legal range 2..4; any other value is an elaboration error.
- ADDRWIDTH, 3: each pointer is ADDRWIDTH+1 bits (W).
- NUM_CH, 1: number of independent pointer channels. Legal range 1..8.

Ports (clock and reset first):
- clk, in, 1: destination-domain clock.
- arstn, in, 1: reset, asynchronous, active-low.
- srstn, in, 1: synchronous reset, active-low, equivalent in effect to arstn.
- inp, in, NUM_CH*W: Gray pointers from the source domain. Channel c occupies bits [c*W +: W].
- err_clr, in, 1: clears all sticky error flags.
- sync_gray, out, NUM_CH*W: synchronized Gray pointers.
- sync_bin, out, NUM_CH*W: binary equivalents of sync_gray, registered.
- chg, out, NUM_CH: per-channel one-cycle pulse when the synchronized value changes.
- err, out, NUM_CH: per-channel sticky flag for an illegal Gray transition.
- ready, out, 1: start-up flush complete; synchronized outputs are meaningful.

## Operation
- Each channel has its own NUM_STAGES-deep shift chain.
  - Stage 1 samples inp.
  - The last stage drives sync_gray.
  - All stages reset to 0.
- Binary conversion: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i]. The result is registered into sync_bin.
- Each channel keeps a prev register holding the previous sync_gray value, reset to 0.
- chg[c] is registered high for one cycle whenever sync_gray[c] != prev[c].
- Hamming check: if ready=1 and popcount(sync_gray[c]^prev[c]) > 1, err[c] sets on the next edge.
  - err[c] stays set until err_clr is sampled high.
  - A set and err_clr in the same cycle: set wins, so err stays 1.
- Start-up counter, width clog2(NUM_STAGES+2):
  - Counts 0 to NUM_STAGES+1 after reset release, then saturates.
  - ready = (count == NUM_STAGES+1).
  - While ready=0, err is never set. chg and sync_bin still operate.
- Reset behaviour (arstn low, or srstn sampled low):
  - All chains, prev, sync_gray, sync_bin, chg, err and the counter go to 0; ready=0.
  - Reset applies to all channels at once and may occur mid-operation; nothing is retained.
  - After srstn deasserts, the counter restarts from 0.
- Wrap-around needs no special handling. Gray max to 0 is a single-bit change: no err, and sync_bin wraps to 0.
- Channels are fully independent. An error on one channel never affects another.

## Timing
- If inp changes before edge k, then:
  - sync_gray shows the new value after edge k+NUM_STAGES-1, which is NUM_STAGES register delays.
  - sync_bin and chg follow one edge later.
  - err follows one further edge later, because it is evaluated from sync_gray against prev.
- ready rises NUM_STAGES+1 edges after reset deassertion (the first edge with arstn=1 and srstn=1 is edge 0).
- err_clr acts on the edge where it is sampled; err reads 0 on the following cycle, unless a set occurs in the same cycle.
- Steady-state throughput: one pointer update per clk per channel.
- Gray changes that are consistently at most one bit per cycle never produce err.

## Test plan
- Reset: hold arstn=0 while inp toggles.
  - All outputs must read 0.
  - After release with NUM_STAGES=2, ready=1 exactly 3 edges later.
- Latency (NUM_STAGES=2, ADDRWIDTH=3): step inp from 0000 to 0001.
  - sync_gray=0001 two edges later.
  - sync_bin=0001 with chg=1 for exactly one cycle on the third edge.
  - err stays 0.
- Wrap: drive the Gray sequence through 1000 (bin 15) then to 0000.
  - sync_bin goes 15 to 0, chg pulses, err=0.
- Illegal jump after ready: drive inp 0000 to 0011.
  - err=1, sticky.
  - err_clr=1 alone clears it.
  - err_clr asserted on the same edge as a new illegal jump leaves err=1.
- Start-up masking: apply an illegal jump before ready.
  - err=0; chg and sync_bin still follow the input.
- Multi-channel plus srstn (NUM_CH=4): illegal jump on channel 2 only.
  - Only err[2] sets.
  - srstn=0 mid-stream zeroes all channels and ready.
  - The ready sequence then repeats.

Source files
------------

// File: rtl/corefifo_ptr_sync_mc.sv
// Multi-channel N-stage Gray pointer synchronizer for the destination domain of an async FIFO.
// Per channel: resync chain, registered binary view, change pulse and sticky illegal-transition flag.

module corefifo_ptr_sync_lane #(
    parameter int NUM_STAGES = 2,
    parameter int W          = 4
) (
    input  logic         clk,
    input  logic         arstn,
    input  logic         srstn,
    input  logic         ready,
    input  logic         err_clr,
    input  logic [W-1:0] inp,
    output logic [W-1:0] sync_gray,
    output logic [W-1:0] sync_bin,
    output logic         chg,
    output logic         err
);
    logic [NUM_STAGES-1:0][W-1:0] chain;
    logic [W-1:0]                 prev;
    logic [W-1:0]                 diff;
    logic                         multi;

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    assign sync_gray = chain[NUM_STAGES-1];
    assign diff      = sync_gray ^ prev;

    // multi registers the >1-bit test so err lands one edge after chg;
    // x & (x-1) is non-zero exactly when more than one bit is set.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            chain    <= '0;
            prev     <= '0;
            sync_bin <= '0;
            chg      <= 1'b0;
            multi    <= 1'b0;
            err      <= 1'b0;
        end else if (!srstn) begin
            chain    <= '0;
            prev     <= '0;
            sync_bin <= '0;
            chg      <= 1'b0;
            multi    <= 1'b0;
            err      <= 1'b0;
        end else begin
            chain    <= {chain[NUM_STAGES-2:0], inp};
            prev     <= sync_gray;
            sync_bin <= gray2bin(sync_gray);
            chg      <= (sync_gray != prev);
            multi    <= ready && (|(diff & (diff - 1'b1)));
            err      <= multi | (err & ~err_clr);
        end
    end
endmodule

module corefifo_ptr_sync_mc #(
    parameter int NUM_STAGES = 2,
    parameter int ADDRWIDTH  = 3,
    parameter int NUM_CH     = 1
) (
    input  logic                            clk,
    input  logic                            arstn,
    input  logic                            srstn,
    input  logic [NUM_CH*(ADDRWIDTH+1)-1:0] inp,
    input  logic                            err_clr,
    output logic [NUM_CH*(ADDRWIDTH+1)-1:0] sync_gray,
    output logic [NUM_CH*(ADDRWIDTH+1)-1:0] sync_bin,
    output logic [NUM_CH-1:0]               chg,
    output logic [NUM_CH-1:0]               err,
    output logic                            ready
);
    localparam int W  = ADDRWIDTH + 1;
    localparam int CW = $clog2(NUM_STAGES + 2);

    if (NUM_STAGES < 2 || NUM_STAGES > 4) begin : g_bad_stages
        $error("corefifo_ptr_sync_mc: NUM_STAGES must be 2..4");
    end
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_ch
        $error("corefifo_ptr_sync_mc: NUM_CH must be 1..8");
    end

    logic [CW-1:0] cnt;

    // Start-up qualifier: saturates once the chains have flushed the reset zeros.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn)      cnt <= '0;
        else if (!srstn) cnt <= '0;
        else if (!ready) cnt <= cnt + 1'b1;
    end

    assign ready = (cnt == CW'(NUM_STAGES + 1));

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        corefifo_ptr_sync_lane #(
            .NUM_STAGES(NUM_STAGES),
            .W         (W)
        ) u_lane (
            .clk      (clk),
            .arstn    (arstn),
            .srstn    (srstn),
            .ready    (ready),
            .err_clr  (err_clr),
            .inp      (inp[c*W +: W]),
            .sync_gray(sync_gray[c*W +: W]),
            .sync_bin (sync_bin[c*W +: W]),
            .chg      (chg[c]),
            .err      (err[c])
        );
    end
endmodule

// File: tb/tb_corefifo_ptr_sync_mc.sv
// Directed bench: 2 stages, 4-bit pointers, 4 channels; expected values hand-computed.

module tb_corefifo_ptr_sync_mc;
    logic        clk = 1'b0;
    logic        arstn;
    logic        srstn;
    logic [15:0] inp;
    logic        err_clr;
    logic [15:0] sync_gray;
    logic [15:0] sync_bin;
    logic [3:0]  chg;
    logic [3:0]  err;
    logic        ready;

    int checks = 0;
    int errors = 0;

    corefifo_ptr_sync_mc #(.NUM_STAGES(2), .ADDRWIDTH(3), .NUM_CH(4)) dut (
        .clk      (clk),
        .arstn    (arstn),
        .srstn    (srstn),
        .inp      (inp),
        .err_clr  (err_clr),
        .sync_gray(sync_gray),
        .sync_bin (sync_bin),
        .chg      (chg),
        .err      (err),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        arstn = 1'b0; srstn = 1'b1; err_clr = 1'b0; inp = '0;

        // async reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            inp = 16'($urandom);
            tick();
        end
        chk("rst_gray",  32'(sync_gray), 32'h0);
        chk("rst_bin",   32'(sync_bin),  32'h0);
        chk("rst_chg",   32'(chg),       32'h0);
        chk("rst_err",   32'(err),       32'h0);
        chk("rst_ready", 32'(ready),     32'h0);

        // release with an illegal jump pending on ch0: masked by start-up
        inp = '0; inp[3:0] = 4'b0011; arstn = 1'b1;
        tick();
        chk("rdy_e0", 32'(ready), 32'h0);
        tick();
        chk("rdy_e1", 32'(ready), 32'h0);
        chk("mask_gray", 32'(sync_gray[3:0]), 32'h3);
        tick();
        chk("rdy_e2", 32'(ready), 32'h1);
        chk("mask_chg", 32'(chg[0]), 32'h1);
        chk("mask_bin", 32'(sync_bin[3:0]), 32'h2);
        tick();
        chk("mask_err", 32'(err), 32'h0);
        chk("mask_chg_off", 32'(chg[0]), 32'h0);

        inp[3:0] = 4'b0001; tick(4);
        inp[3:0] = 4'b0000; tick(4);
        chk("settle_bin", 32'(sync_bin[3:0]), 32'h0);
        chk("settle_err", 32'(err), 32'h0);

        // latency 0000 -> 0001
        inp[3:0] = 4'b0001;
        tick();
        chk("lat_k_gray", 32'(sync_gray[3:0]), 32'h0);
        tick();
        chk("lat_k1_gray", 32'(sync_gray[3:0]), 32'h1);
        chk("lat_k1_bin",  32'(sync_bin[3:0]),  32'h0);
        chk("lat_k1_chg",  32'(chg[0]),         32'h0);
        tick();
        chk("lat_k2_bin", 32'(sync_bin[3:0]), 32'h1);
        chk("lat_k2_chg", 32'(chg[0]),        32'h1);
        tick();
        chk("lat_k3_chg", 32'(chg[0]), 32'h0);
        chk("lat_k3_err", 32'(err),    32'h0);

        // walk the Gray sequence one step per cycle, then wrap 1000 -> 0000
        for (int i = 2; i < 16; i++) begin
            inp[3:0] = 4'(i ^ (i >> 1));
            tick();
        end
        tick(3);
        chk("wrap_bin15", 32'(sync_bin[3:0]), 32'hf);
        chk("wrap_err15", 32'(err), 32'h0);
        inp[3:0] = 4'b0000;
        tick(3);
        chk("wrap_bin0", 32'(sync_bin[3:0]), 32'h0);
        chk("wrap_chg",  32'(chg[0]),        32'h1);
        tick();
        chk("wrap_err", 32'(err), 32'h0);

        // illegal jump 0000 -> 0011 after ready
        inp[3:0] = 4'b0011;
        tick(3);
        chk("ill_chg",    32'(chg[0]), 32'h1);
        chk("ill_err_k2", 32'(err),    32'h0);
        tick();
        chk("ill_err_set", 32'(err), 32'h1);
        tick(2);
        chk("ill_sticky", 32'(err), 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ill_clr", 32'(err), 32'h0);
        tick();
        chk("ill_clr_hold", 32'(err), 32'h0);

        // illegal jump 0011 -> 1100 with err_clr on the setting edge
        inp[3:0] = 4'b1100;
        tick(3);
        chk("same_pre", 32'(err), 32'h0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("same_set_wins", 32'(err), 32'h1);
        tick();
        chk("same_sticky", 32'(err), 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("same_clr", 32'(err), 32'h0);

        // channel 2 only: 0000 -> 0110
        inp[11:8] = 4'b0110;
        tick(4);
        chk("mc_err", 32'(err), 32'h4);
        chk("mc_bin2", 32'(sync_bin[11:8]), 32'h4);
        chk("mc_bin0", 32'(sync_bin[3:0]),  32'h8);

        // synchronous reset mid-stream
        srstn = 1'b0;
        tick();
        chk("srst_gray",  32'(sync_gray), 32'h0);
        chk("srst_bin",   32'(sync_bin),  32'h0);
        chk("srst_chg",   32'(chg),       32'h0);
        chk("srst_err",   32'(err),       32'h0);
        chk("srst_ready", 32'(ready),     32'h0);
        tick();
        chk("srst_hold_gray", 32'(sync_gray), 32'h0);
        srstn = 1'b1;
        tick();
        chk("srdy_e0", 32'(ready), 32'h0);
        tick();
        chk("srdy_e1", 32'(ready), 32'h0);
        chk("srdy_gray0", 32'(sync_gray[3:0]), 32'hc);
        tick();
        chk("srdy_e2", 32'(ready), 32'h1);
        chk("srdy_bin0", 32'(sync_bin[3:0]), 32'h8);
        chk("srdy_bin2", 32'(sync_bin[11:8]), 32'h4);
        tick(2);
        chk("srdy_err_masked", 32'(err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
